timer_spr_wr_ctl: RTL
=====================

TIMER_SPR_WR_CTL -- requirements
Module: timer_spr_wr_ctl

Interface
REQ-001 SHALL have ports: CB  in  1  clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: sprDataIn  in  [0:31]  mtspr write data.
REQ-004 SHALL have ports: mtsprValid  in  1  qualifies a write this cycle.
REQ-005 SHALL have ports: tsrDcd  in  1  TSR write-one-to-clear select.
REQ-006 SHALL have ports: tcrDcd  in  1  TCR write select.
REQ-007 SHALL have ports: pitDcd  in  1  PIT write select.
REQ-008 SHALL have ports: pitTick  in  1  PIT decrement enable.
REQ-009 SHALL have ports: wdTbBits  in  [0:3]  time-base taps for the watchdog period.
REQ-010 SHALL have ports: fitTbBits  in  [0:3]  time-base taps for the FIT period.
REQ-011 SHALL have ports: timerStatusOutL2  out  [0:5]  TSR: 0 ENW, 1 WIS, 2:3 WRS, 4 PIS, 5 FIS.
REQ-012 SHALL have ports: timerControlL2  out  [0:9]  TCR: 0:1 WP, 2:3 WRC, 4 WIE, 5 PIE, 6:7 FP, 8 FIE, 9 ARE.
REQ-013 SHALL have ports: pitL2  out  [0:31]  current PIT count.
REQ-014 SHALL have ports: wdResetReq  out  [0:1]  one-cycle watchdog reset request carrying the WRC code.
REQ-015 SHALL register all outputs, with no combinational path from any input to any output.

Function
REQ-016 SHALL select the watchdog tap as wdTbBits[WP] and the FIT tap as fitTbBits[FP], each WP/FP value indexing bits 0..3.
REQ-017 SHALL register each selected tap and generate an event on its 0->1 transition; the event is used the cycle after the edge (one-cycle latency).
REQ-018 SHALL set FIS on each FIT event.
REQ-019 SHALL advance the watchdog on each watchdog event: ENW=0 -> set ENW; ENW=1,WIS=0 -> set WIS; ENW=1,WIS=1,WRC!=0 -> WRS<=WRC and pulse wdResetReq=WRC for one cycle; ENW=1,WIS=1,WRC=0 -> no change.
REQ-020 SHALL, on a TSR write (mtsprValid&tsrDcd), clear each TSR bit whose sprDataIn bit is 1, using sprDataIn[0:5] to map TSR[0:5].
REQ-021 SHALL give a set event priority over a same-cycle TSR clear of the same bit.
REQ-022 SHALL, on a TCR write, load WP, WIE, PIE, FP, FIE and ARE from sprDataIn[0:1], [4], [5], [6:7], [8] and [9].
REQ-023 SHALL make WRC sticky: a TCR write updates WRC only while WRC=0, and once nonzero WRC changes only on reset.
REQ-024 SHALL, on a PIT write, load pitL2 and a 32-bit reload register from sprDataIn.
REQ-025 SHALL decrement pitL2 by 1 on pitTick when pitL2!=0, and hold it at 0 without wrapping.
REQ-026 SHALL, on a pitTick decrement from 1 to 0, set PIS and, if ARE=1, load pitL2 from the reload register instead of 0 in that same cycle.
REQ-027 SHALL give a PIT write priority over a same-cycle pitTick (write value taken, no decrement).
REQ-028 SHALL apply a TCR write that changes WP/FP starting next cycle and re-seed the edge register with the new tap, so a selection change alone produces no event.
REQ-029 SHALL ignore any write with mtsprValid=0, and SHALL accept at most one decode per cycle (decodes are mutually exclusive).

Reset
REQ-030 SHALL, while reset=1, clear timerStatusOutL2, timerControlL2, pitL2, the reload register, the edge registers and wdResetReq to 0.
REQ-031 SHALL let a reset asserted mid-countdown or between watchdog stages abandon all progress, with the first event after reset release seeing ENW=0.
REQ-032 SHALL resume normal operation on the first edge with reset=0.

Verification
REQ-033 SHALL cover the watchdog sequence: TCR write WRC=2'b10, then three rising edges on the selected wdTbBits -> ENW=1, then WIS=1, then WRS=2'b10 with a single-cycle wdResetReq=2'b10.
REQ-034 SHALL cover PIT auto-reload: PIT write 3 with ARE=1, then 3 pitTicks -> pitL2 goes 2,1,3, PIS=1; with ARE=0 -> pitL2 stays 0 and PIS=1.
REQ-035 SHALL cover simultaneous set/clear: a FIT edge in the same cycle as a TSR write with bit5=1 -> FIS=1; the next TSR write with bit5=1 and no event -> FIS=0.
REQ-036 SHALL cover sticky WRC: TCR write WRC=2'b01, then TCR write WRC=2'b11 -> WRC stays 2'b01 while the other TCR fields update.
REQ-037 SHALL cover write priority: PIT write 0x10 with pitTick in the same cycle -> pitL2=0x10.
REQ-038 SHALL cover mid-operation reset: reset asserted with ENW=1, WIS=1, pitL2=5 -> all outputs 0 the next cycle, and a following watchdog edge sets only ENW.

Source files
------------

// File: rtl/timer_spr_wr_ctl.sv
// Timer SPR write control: TSR/TCR/PIT registers, watchdog stage machine,
// FIT status and the PIT down-counter with optional auto-reload.

// Per-tap rising-edge detector. The selected time-base tap is registered and a
// 0->1 transition is flagged one cycle later. On a TCR write the history
// register is seeded with the tap chosen by the new selection, so a change of
// selection on its own never looks like an edge.
module timer_tap_edge (
  input  logic       CB,
  input  logic       reset,
  input  logic [0:3] tbBits,
  input  logic [0:1] sel,
  input  logic       reseed,
  input  logic [0:1] reseedSel,
  output logic       evt
);

  logic tapQ;

  // sample the selected tap and register its rising edge
  always_ff @(posedge CB) begin
    if (reset) begin
      tapQ <= 1'b0;
      evt  <= 1'b0;
    end else begin
      evt  <= tbBits[sel] & ~tapQ;
      tapQ <= reseed ? tbBits[reseedSel] : tbBits[sel];
    end
  end

endmodule

module timer_spr_wr_ctl (
  input  logic        CB,
  input  logic        reset,
  input  logic [0:31] sprDataIn,
  input  logic        mtsprValid,
  input  logic        tsrDcd,
  input  logic        tcrDcd,
  input  logic        pitDcd,
  input  logic        pitTick,
  input  logic [0:3]  wdTbBits,
  input  logic [0:3]  fitTbBits,
  output logic [0:5]  timerStatusOutL2,
  output logic [0:9]  timerControlL2,
  output logic [0:31] pitL2,
  output logic [0:1]  wdResetReq
);

  localparam int NUM_TAPS = 2;   // tap 0: watchdog, tap 1: FIT
  localparam int TAP_WD   = 0;
  localparam int TAP_FIT  = 1;

  // Decodes are exclusive by contract; the fixed priority below only keeps
  // the logic well defined if that is ever violated.
  logic tsrWr, tcrWr, pitWr;
  assign tsrWr = mtsprValid & tsrDcd;
  assign tcrWr = mtsprValid & tcrDcd & ~tsrDcd;
  assign pitWr = mtsprValid & pitDcd & ~tsrDcd & ~tcrDcd;

  // TCR fields
  logic [0:1] wp, wrc, fp;
  logic       are;
  assign wp  = timerControlL2[0:1];
  assign wrc = timerControlL2[2:3];
  assign fp  = timerControlL2[6:7];
  assign are = timerControlL2[9];

  logic [0:31] pitReload;

  // ---------------------------------------------------------------------------
  // Tap edge detection, one lane per timer source
  // ---------------------------------------------------------------------------
  logic [0:NUM_TAPS-1][0:3] tapBits;
  logic [0:NUM_TAPS-1][0:1] tapSel;
  logic [0:NUM_TAPS-1][0:1] tapNewSel;
  logic [0:NUM_TAPS-1]      tapEvt;

  assign tapBits[TAP_WD]    = wdTbBits;
  assign tapBits[TAP_FIT]   = fitTbBits;
  assign tapSel[TAP_WD]     = wp;
  assign tapSel[TAP_FIT]    = fp;
  assign tapNewSel[TAP_WD]  = sprDataIn[0:1];
  assign tapNewSel[TAP_FIT] = sprDataIn[6:7];

  for (genvar g = 0; g < NUM_TAPS; g++) begin : gTap
    timer_tap_edge uEdge (
      .CB        (CB),
      .reset     (reset),
      .tbBits    (tapBits[g]),
      .sel       (tapSel[g]),
      .reseed    (tcrWr),
      .reseedSel (tapNewSel[g]),
      .evt       (tapEvt[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Next-state computation
  // ---------------------------------------------------------------------------
  logic [0:5]  tsrSet, tsrClr, tsrNext;
  logic [0:9]  tcrNext;
  logic [0:31] pitNext, reloadNext;
  logic [0:1]  wdReqNext;
  logic        wrsLoad;

  // watchdog stage advance, FIT status and PIT countdown
  always_comb begin
    tsrSet     = '0;
    wrsLoad    = 1'b0;
    wdReqNext  = '0;
    pitNext    = pitL2;
    reloadNext = pitReload;

    // watchdog: first event arms ENW, second raises WIS, third fires reset
    if (tapEvt[TAP_WD]) begin
      if (!timerStatusOutL2[0]) begin
        tsrSet[0] = 1'b1;
      end else if (!timerStatusOutL2[1]) begin
        tsrSet[1] = 1'b1;
      end else if (wrc != 2'b00) begin
        wrsLoad   = 1'b1;
        wdReqNext = wrc;
      end
    end

    if (tapEvt[TAP_FIT]) tsrSet[5] = 1'b1;

    // a PIT write overrides a same-cycle tick; the count parks at zero
    if (pitWr) begin
      pitNext    = sprDataIn;
      reloadNext = sprDataIn;
    end else if (pitTick && (pitL2 != 32'd0)) begin
      if (pitL2 == 32'd1) begin
        tsrSet[4] = 1'b1;
        pitNext   = are ? pitReload : 32'd0;
      end else begin
        pitNext = pitL2 - 32'd1;
      end
    end
  end

  // TSR write-one-to-clear, with same-cycle set events winning
  always_comb begin
    tsrClr  = tsrWr ? sprDataIn[0:5] : 6'b0;
    tsrNext = (timerStatusOutL2 & ~tsrClr) | tsrSet;
    if (wrsLoad) tsrNext[2:3] = wrc;
  end

  // TCR load; WRC latches once and is then only cleared by reset
  always_comb begin
    tcrNext = timerControlL2;
    if (tcrWr) begin
      tcrNext[0:1] = sprDataIn[0:1];
      if (wrc == 2'b00) tcrNext[2:3] = sprDataIn[2:3];
      tcrNext[4:9] = sprDataIn[4:9];
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural state; every output comes straight from a flop
  // ---------------------------------------------------------------------------
  // state register update with synchronous reset
  always_ff @(posedge CB) begin
    if (reset) begin
      timerStatusOutL2 <= '0;
      timerControlL2   <= '0;
      pitL2            <= '0;
      pitReload        <= '0;
      wdResetReq       <= '0;
    end else begin
      timerStatusOutL2 <= tsrNext;
      timerControlL2   <= tcrNext;
      pitL2            <= pitNext;
      pitReload        <= reloadNext;
      wdResetReq       <= wdReqNext;
    end
  end

endmodule
